// File: rtl/difftest_commit_queue.sv
// difftest_commit_queue
// Multi-lane commit capture queue feeding the difftest/DPI bridge.
// Up to NCH retired instructions per cycle are compacted in lane order into
// a DEPTH-entry FIFO and drained one per cycle with a sequence number.
// An ebreak is reported only after every commit older than it has drained.
module difftest_commit_queue #(
    parameter int XLEN  = 64,
    parameter int NCH   = 2,
    parameter int DEPTH = 8,
    parameter int SEQW  = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NCH-1:0]            in_valid,
    input  logic [NCH*XLEN-1:0]       in_pc,
    input  logic [NCH*32-1:0]         in_inst,
    input  logic [NCH-1:0]            in_wen,
    input  logic [NCH*5-1:0]          in_wdest,
    input  logic [NCH*XLEN-1:0]       in_wdata,
    output logic                      in_stall,
    input  logic                      ebreak_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_pc,
    output logic [31:0]               out_inst,
    output logic                      out_wen,
    output logic [4:0]                out_wdest,
    output logic [XLEN-1:0]           out_wdata,
    output logic [SEQW-1:0]           out_seq,
    output logic                      ebreak_out,
    output logic                      overflow,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]   r_rdPtr;
    logic [AW-1:0]   r_wrPtr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_drain;
    logic [SEQW-1:0] r_seq;
    logic            r_pend;
    logic            r_ebreakOut;
    logic            r_overflow;

    logic [XLEN-1:0] r_memPc    [DEPTH];
    logic [31:0]     r_memInst  [DEPTH];
    logic            r_memWen   [DEPTH];
    logic [4:0]      r_memWdest [DEPTH];
    logic [XLEN-1:0] r_memWdata [DEPTH];
    logic [SEQW-1:0] r_memSeq   [DEPTH];

    logic [CW-1:0]   w_free;
    logic            w_accept;
    logic            w_pop;
    logic [CW-1:0]   w_validCnt;
    logic [CW-1:0]   w_pushCnt;
    logic [CW-1:0]   w_laneOfs  [NCH];
    logic [AW-1:0]   w_slot     [NCH];
    logic [CW-1:0]   w_countNext;
    logic            w_newEbreak;
    logic            w_pendEff;
    logic [CW-1:0]   w_drainNext;
    logic            w_fire;

    // Backpressure looks only at the registered count, so a pop in the same
    // cycle never opens room for a push; this keeps in_stall off the ready path.
    assign w_free   = CW'(DEPTH) - r_count;
    assign in_stall = w_free < CW'(NCH);
    assign w_accept = !in_stall;

    assign out_valid = (r_count != '0);
    assign w_pop     = out_valid && out_ready;

    assign out_pc     = r_memPc[r_rdPtr];
    assign out_inst   = r_memInst[r_rdPtr];
    assign out_wen    = r_memWen[r_rdPtr];
    assign out_wdest  = r_memWdest[r_rdPtr];
    assign out_wdata  = r_memWdata[r_rdPtr];
    assign out_seq    = r_memSeq[r_rdPtr];
    assign ebreak_out = r_ebreakOut;
    assign overflow   = r_overflow;
    assign occupancy  = r_count;

    // Compaction: each valid lane lands at wr_ptr plus the number of valid
    // lanes below it, so holes in in_valid never leave holes in the FIFO.
    always_comb begin
        w_validCnt = '0;
        for (int i = 0; i < NCH; i++) begin
            w_laneOfs[i] = w_validCnt;
            w_slot[i]    = r_wrPtr + AW'(w_validCnt);
            w_validCnt   = w_validCnt + CW'(in_valid[i]);
        end
    end

    assign w_pushCnt   = w_accept ? w_validCnt : '0;
    assign w_countNext = r_count + w_pushCnt - CW'(w_pop);

    // The drain counter holds how many entries older than the pending ebreak
    // are still queued; same-cycle commits count as older than the ebreak.
    always_comb begin
        w_newEbreak = ebreak_in && !r_pend;
        w_pendEff   = r_pend || ebreak_in;
        w_drainNext = r_drain;
        if (w_newEbreak) begin
            w_drainNext = w_countNext;
        end else if (r_pend && w_pop) begin
            w_drainNext = r_drain - CW'(1);
        end
        w_fire = w_pendEff && (w_drainNext == '0);
    end

    // Pointers, occupancy, sequence number, overflow flag and ebreak tracking.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rdPtr     <= '0;
            r_wrPtr     <= '0;
            r_count     <= '0;
            r_drain     <= '0;
            r_seq       <= '0;
            r_pend      <= 1'b0;
            r_ebreakOut <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_rdPtr     <= r_rdPtr + AW'(w_pop);
            r_wrPtr     <= r_wrPtr + AW'(w_pushCnt);
            r_count     <= w_countNext;
            r_seq       <= r_seq + SEQW'(w_pushCnt);
            r_drain     <= w_drainNext;
            r_pend      <= w_pendEff && !w_fire;
            r_ebreakOut <= w_fire;
            if (in_stall && (|in_valid)) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Entry storage: accepted lanes are written to their compacted slots,
    // each tagged with the running sequence number plus its lane offset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int d = 0; d < DEPTH; d++) begin
                r_memPc[d]    <= '0;
                r_memInst[d]  <= '0;
                r_memWen[d]   <= 1'b0;
                r_memWdest[d] <= '0;
                r_memWdata[d] <= '0;
                r_memSeq[d]   <= '0;
            end
        end else if (w_accept) begin
            for (int i = 0; i < NCH; i++) begin
                if (in_valid[i]) begin
                    r_memPc[w_slot[i]]    <= in_pc[XLEN*i +: XLEN];
                    r_memInst[w_slot[i]]  <= in_inst[32*i +: 32];
                    r_memWen[w_slot[i]]   <= in_wen[i];
                    r_memWdest[w_slot[i]] <= in_wdest[5*i +: 5];
                    r_memWdata[w_slot[i]] <= in_wdata[XLEN*i +: XLEN];
                    r_memSeq[w_slot[i]]   <= r_seq + SEQW'(w_laneOfs[i]);
                end
            end
        end
    end

endmodule

// File: tb/tb_difftest_commit_queue.sv
// tb_difftest_commit_queue
// Scoreboard bench for difftest_commit_queue with NCH=2, DEPTH=8.
`timescale 1ns/1ps
module tb_difftest_commit_queue;

    localparam int XLEN  = 64;
    localparam int NCH   = 2;
    localparam int DEPTH = 8;
    localparam int SEQW  = 16;

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic [NCH-1:0]         in_valid = '0;
    logic [NCH*XLEN-1:0]    in_pc = '0;
    logic [NCH*32-1:0]      in_inst = '0;
    logic [NCH-1:0]         in_wen = '0;
    logic [NCH*5-1:0]       in_wdest = '0;
    logic [NCH*XLEN-1:0]    in_wdata = '0;
    logic                   in_stall;
    logic                   ebreak_in = 1'b0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [XLEN-1:0]        out_pc;
    logic [31:0]            out_inst;
    logic                   out_wen;
    logic [4:0]             out_wdest;
    logic [XLEN-1:0]        out_wdata;
    logic [SEQW-1:0]        out_seq;
    logic                   ebreak_out;
    logic                   overflow;
    logic [$clog2(DEPTH):0] occupancy;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic            wen;
        logic [4:0]      wdest;
        logic [XLEN-1:0] wdata;
        logic [SEQW-1:0] seq;
    } entry_t;

    entry_t          sbQ[$];
    logic [SEQW-1:0] mSeq = '0;
    int              nChecks = 0;
    int              nPass = 0;

    difftest_commit_queue #(
        .XLEN(XLEN), .NCH(NCH), .DEPTH(DEPTH), .SEQW(SEQW)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
        .in_wen(in_wen), .in_wdest(in_wdest), .in_wdata(in_wdata),
        .in_stall(in_stall), .ebreak_in(ebreak_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_wen(out_wen),
        .out_wdest(out_wdest), .out_wdata(out_wdata), .out_seq(out_seq),
        .ebreak_out(ebreak_out), .overflow(overflow), .occupancy(occupancy)
    );

    // Free-running clock, 10 ns period.
    always #5 clock = ~clock;

    // Drive one lane with a pc and data fields derived from it.
    task automatic setLane(input int i, input logic [XLEN-1:0] pc);
        in_pc[XLEN*i +: XLEN] = pc;
        in_inst[32*i +: 32]   = pc[31:0] ^ 32'h0000_0013;
        in_wen[i]             = pc[2];
        in_wdest[5*i +: 5]    = pc[6:2];
        in_wdata[XLEN*i +: XLEN] = ~pc;
    endtask

    // Advance one cycle: predict pops/pushes from the scoreboard occupancy,
    // compare any popped head against the oldest expected entry.
    task automatic tick();
        entry_t e;
        entry_t exp;
        bit     stalled;
        bit     pop;
        int     k;
        #2;
        stalled = (DEPTH - sbQ.size()) < NCH;
        pop = (sbQ.size() != 0) && out_ready;
        if (pop) begin
            exp = sbQ.pop_front();
            nChecks++;
            if (out_valid !== 1'b1 || out_pc !== exp.pc || out_inst !== exp.inst ||
                out_wen !== exp.wen || out_wdest !== exp.wdest ||
                out_wdata !== exp.wdata || out_seq !== exp.seq) begin
                $display("[TB] FAIL pop_entry: got valid=%b pc=%h seq=%h inst=%h wen=%b wdest=%0d, want pc=%h seq=%h inst=%h wen=%b wdest=%0d",
                         out_valid, out_pc, out_seq, out_inst, out_wen, out_wdest,
                         exp.pc, exp.seq, exp.inst, exp.wen, exp.wdest);
            end else begin
                nPass++;
            end
        end
        if (!stalled) begin
            k = 0;
            for (int i = 0; i < NCH; i++) begin
                if (in_valid[i]) begin
                    e.pc    = in_pc[XLEN*i +: XLEN];
                    e.inst  = in_inst[32*i +: 32];
                    e.wen   = in_wen[i];
                    e.wdest = in_wdest[5*i +: 5];
                    e.wdata = in_wdata[XLEN*i +: XLEN];
                    e.seq   = mSeq + SEQW'(k);
                    sbQ.push_back(e);
                    k++;
                end
            end
            mSeq = mSeq + SEQW'(k);
        end
        @(posedge clock);
        #1;
    endtask

    // Synchronous reset for one edge, then clear the scoreboard model.
    task automatic applyReset();
        reset = 1'b1;
        in_valid = '0;
        ebreak_in = 1'b0;
        out_ready = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        sbQ.delete();
        mSeq = '0;
    endtask

    task automatic test_reset();
        applyReset();
        nChecks++;
        if ({out_valid, in_stall, overflow, ebreak_out, occupancy} !== '0) begin
            $display("[TB] FAIL reset_flags: got valid=%b stall=%b ovf=%b ebrk=%b occ=%0d, want all 0",
                     out_valid, in_stall, overflow, ebreak_out, occupancy);
        end else nPass++;
        nChecks++;
        if ({out_pc, out_inst, out_seq, out_wdata} !== '0) begin
            $display("[TB] FAIL reset_data: got pc=%h inst=%h seq=%h, want 0", out_pc, out_inst, out_seq);
        end else nPass++;
    endtask

    task automatic test_dual_push();
        applyReset();
        out_ready = 1'b1;
        in_valid = 2'b11;
        setLane(0, 64'h8000_0000);
        setLane(1, 64'h8000_0004);
        tick();
        in_valid = 2'b00;
        nChecks++;
        if (out_valid !== 1'b1 || out_pc !== 64'h8000_0000 || out_seq !== 16'd0) begin
            $display("[TB] FAIL dual_first: got valid=%b pc=%h seq=%h, want 1 80000000 0000", out_valid, out_pc, out_seq);
        end else nPass++;
        tick();
        nChecks++;
        if (out_pc !== 64'h8000_0004 || out_seq !== 16'd1) begin
            $display("[TB] FAIL dual_second: got pc=%h seq=%h, want 80000004 0001", out_pc, out_seq);
        end else nPass++;
        tick();
        nChecks++;
        if (occupancy !== 4'd0 || out_valid !== 1'b0) begin
            $display("[TB] FAIL dual_empty: got occ=%0d valid=%b, want 0 0", occupancy, out_valid);
        end else nPass++;
    endtask

    task automatic test_compaction();
        applyReset();
        in_valid = 2'b10;
        setLane(0, 64'hDEAD_BEEF_0000_0000);
        setLane(1, 64'h8000_0010);
        tick();
        in_valid = 2'b00;
        nChecks++;
        if (occupancy !== 4'd1 || out_pc !== 64'h8000_0010 || out_seq !== 16'd0) begin
            $display("[TB] FAIL compaction: got occ=%0d pc=%h seq=%h, want 1 80000010 0000", occupancy, out_pc, out_seq);
        end else nPass++;
        out_ready = 1'b1;
        tick();
        nChecks++;
        if (occupancy !== 4'd0) begin
            $display("[TB] FAIL compaction_drain: got occ=%0d, want 0", occupancy);
        end else nPass++;
    endtask

    task automatic test_overflow();
        applyReset();
        for (int j = 1; j <= 4; j++) begin
            in_valid = 2'b11;
            setLane(0, 64'h8000_1000 + 64'(j * 16));
            setLane(1, 64'h8000_1008 + 64'(j * 16));
            tick();
            nChecks++;
            if (occupancy !== 4'(2 * j) || in_stall !== (j == 4)) begin
                $display("[TB] FAIL fill_%0d: got occ=%0d stall=%b, want %0d %b", j, occupancy, in_stall, 2 * j, (j == 4));
            end else nPass++;
        end
        setLane(0, 64'h8000_2000);
        setLane(1, 64'h8000_2004);
        tick();
        nChecks++;
        if (overflow !== 1'b1 || occupancy !== 4'd8) begin
            $display("[TB] FAIL overflow_set: got ovf=%b occ=%0d, want 1 8", overflow, occupancy);
        end else nPass++;
        out_ready = 1'b1;
        tick();
        nChecks++;
        if (occupancy !== 4'd7 || overflow !== 1'b1) begin
            $display("[TB] FAIL full_pop_stall: got occ=%0d ovf=%b, want 7 1", occupancy, overflow);
        end else nPass++;
        in_valid = 2'b00;
        for (int j = 0; j < 7; j++) tick();
        out_ready = 1'b0;
        in_valid = 2'b11;
        setLane(0, 64'h8000_3000);
        setLane(1, 64'h8000_3004);
        tick();
        in_valid = 2'b00;
        nChecks++;
        if (out_seq !== 16'd8 || occupancy !== 4'd2 || overflow !== 1'b1) begin
            $display("[TB] FAIL seq_after_drop: got seq=%0d occ=%0d ovf=%b, want 8 2 1", out_seq, occupancy, overflow);
        end else nPass++;
        out_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_ebreak_order();
        int pulses;
        applyReset();
        in_valid = 2'b11;
        setLane(0, 64'h8000_4000);
        setLane(1, 64'h8000_4004);
        tick();
        in_valid = 2'b01;
        setLane(0, 64'h8000_4008);
        tick();
        nChecks++;
        if (occupancy !== 4'd3) begin
            $display("[TB] FAIL ebreak_preload: got occ=%0d, want 3", occupancy);
        end else nPass++;
        ebreak_in = 1'b1;
        in_valid = 2'b01;
        setLane(0, 64'h8000_400C);
        out_ready = 1'b1;
        nChecks++;
        if (ebreak_out !== 1'b0) begin
            $display("[TB] FAIL ebreak_early0: got %b, want 0", ebreak_out);
        end else nPass++;
        tick();
        ebreak_in = 1'b0;
        in_valid = 2'b00;
        pulses = 0;
        for (int j = 1; j <= 6; j++) begin
            if (ebreak_out === 1'b1) pulses++;
            nChecks++;
            if (ebreak_out !== (j == 4)) begin
                $display("[TB] FAIL ebreak_cycle_%0d: got %b, want %b", j, ebreak_out, (j == 4));
            end else nPass++;
            if (j == 4) begin
                nChecks++;
                if (occupancy !== 4'd0) begin
                    $display("[TB] FAIL ebreak_drained: got occ=%0d, want 0", occupancy);
                end else nPass++;
            end
            tick();
        end
        nChecks++;
        if (pulses != 1) begin
            $display("[TB] FAIL ebreak_pulses: got %0d, want 1", pulses);
        end else nPass++;
    endtask

    task automatic test_ebreak_empty();
        applyReset();
        ebreak_in = 1'b1;
        tick();
        ebreak_in = 1'b0;
        nChecks++;
        if (ebreak_out !== 1'b1) begin
            $display("[TB] FAIL ebreak_empty: got %b, want 1", ebreak_out);
        end else nPass++;
        tick();
        nChecks++;
        if (ebreak_out !== 1'b0) begin
            $display("[TB] FAIL ebreak_empty_once: got %b, want 0", ebreak_out);
        end else nPass++;
    endtask

    task automatic test_seq_wrap();
        applyReset();
        out_ready = 1'b1;
        in_valid = 2'b01;
        for (int i = 0; i < 65535; i++) begin
            setLane(0, 64'h9000_0000 + 64'(i * 4));
            tick();
        end
        in_valid = 2'b11;
        setLane(0, 64'hA000_0000);
        setLane(1, 64'hA000_0004);
        tick();
        in_valid = 2'b00;
        nChecks++;
        if (out_seq !== 16'hFFFF || out_pc !== 64'hA000_0000) begin
            $display("[TB] FAIL seq_ffff: got seq=%h pc=%h, want ffff a0000000", out_seq, out_pc);
        end else nPass++;
        tick();
        nChecks++;
        if (out_seq !== 16'h0000 || out_pc !== 64'hA000_0004) begin
            $display("[TB] FAIL seq_wrap0: got seq=%h pc=%h, want 0000 a0000004", out_seq, out_pc);
        end else nPass++;
        tick();
    endtask

    task automatic test_reset_midop();
        applyReset();
        in_valid = 2'b11;
        for (int j = 0; j < 5; j++) begin
            setLane(0, 64'h8000_5000 + 64'(j * 8));
            setLane(1, 64'h8000_5004 + 64'(j * 8));
            tick();
        end
        in_valid = 2'b00;
        out_ready = 1'b1;
        ebreak_in = 1'b1;
        tick();
        ebreak_in = 1'b0;
        tick();
        tick();
        out_ready = 1'b0;
        nChecks++;
        if (occupancy !== 4'd5 || overflow !== 1'b1 || ebreak_out !== 1'b0) begin
            $display("[TB] FAIL midop_setup: got occ=%0d ovf=%b ebrk=%b, want 5 1 0", occupancy, overflow, ebreak_out);
        end else nPass++;
        applyReset();
        nChecks++;
        if (out_valid !== 1'b0 || occupancy !== 4'd0 || overflow !== 1'b0 || ebreak_out !== 1'b0) begin
            $display("[TB] FAIL midop_reset: got valid=%b occ=%0d ovf=%b ebrk=%b, want 0 0 0 0",
                     out_valid, occupancy, overflow, ebreak_out);
        end else nPass++;
        out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            tick();
            nChecks++;
            if (ebreak_out !== 1'b0) begin
                $display("[TB] FAIL midop_no_ebreak_%0d: got %b, want 0", j, ebreak_out);
            end else nPass++;
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_dual_push();
        test_compaction();
        test_overflow();
        test_ebreak_order();
        test_ebreak_empty();
        test_seq_wrap();
        test_reset_midop();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
